mul_iter_param: RTL
===================

Name: mul_iter_param

Overview:
- Parametrised iterative integer multiplier for the RV32M/RV64M MUL/MULH/MULHSU/MULHU group.
- Next generation of the core's fixed 32-bit Karatsuba/Booth multiplier. Adds:
  - configurable XLEN and bits retired per cycle;
  - a clean start/busy/done handshake;
  - abort support.
- Sits beside the ALU. It is fed by decode with rs1/rs2 and the low funct3 bits, and returns an XLEN result to writeback.

Parameters:
- XLEN, 32, operand/result width; must be 32 or 64.
- BPC, 2, multiplier bits retired per iteration cycle; must be 1, 2 or 4, and must divide XLEN.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- enable  in  1  start request; sampled only when busy=0
- abort  in  1  kill the in-flight operation (pipeline flush)
- op  in  2  operation code: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
- rs1  in  XLEN  multiplicand
- rs2  in  XLEN  multiplier
- rd  out  XLEN  result; holds its value until the next accepted start
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; rd is valid in the same cycle

Behaviour:
- Reset:
  - All outputs are 0 (rd=0, busy=0, done=0).
  - State goes to IDLE.
  - Applies in any state, including mid-operation. No done is produced for a killed operation.
- States and transitions:
  - IDLE: enable=1 moves to PREP. op, rs1 and rs2 are latched at that edge (cycle k). busy=1 from k+1.
  - PREP (1 cycle):
    - Compute the magnitudes |a| and |b|. rs1 is signed for MULH/MULHSU; rs2 is signed for MULH only.
    - Compute the result sign: sign(a) XOR sign(b) for signed operands; 0 otherwise.
    - Clear the 2*XLEN accumulator and load the iteration counter with N = XLEN/BPC.
  - ITER (N cycles):
    - Each cycle: acc += |a| * (low BPC bits of the multiplier register), shifted into place. The multiplier register then shifts right by BPC.
    - The counter decrements and wraps to FIX when it reaches 0.
  - FIX (1 cycle):
    - Negate the 2*XLEN product if the result sign is 1.
    - rd = low XLEN bits for MUL; high XLEN bits otherwise.
    - done=1 and busy=0 in this cycle; next state is IDLE.
- Latency: done in cycle k+N+2. Examples: XLEN=32, BPC=2 gives k+18; BPC=1 gives k+34.
- Back-to-back: enable in the done cycle is accepted (IDLE behaviour applies), giving throughput of one op per N+2 cycles.
- enable while busy=1 is ignored. Inputs are not re-sampled.
- abort while busy=1: return to IDLE next cycle with busy=0. rd keeps its previous value and no done is pulsed. abort in IDLE is a no-op. abort and enable in the same IDLE cycle: abort wins and nothing starts.
- The most-negative operand (e.g. 0x80000000) has magnitude 2^(XLEN-1), held unsigned in XLEN bits. No overflow is possible because the accumulator is 2*XLEN.
- Undefined op values cannot occur (the 2-bit code is exhaustive).

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- Defined: PREP detects rs1==0 or rs2==0 and jumps straight to FIX with product 0. done then pulses at k+2 with rd=0.
- Undefined: zero operands take the full N+2 latency. The result is identical.

Decomposition:
- Shared package mul_pkg holds:
  - op encodings (MUL_OP_MUL/MULH/MULHSU/MULHU);
  - state enum (IDLE, PREP, ITER, FIX);
  - the legal BPC values, checked by elaboration assertions.
- One natural sub-module: mul_step, a combinational partial-product adder that computes acc + (|a| * digit) for one BPC-bit digit. It is instantiated once and reused every iteration.

Test Plan (XLEN=32, BPC=2 unless noted):
- MUL rs1=7, rs2=6, enable at cycle k → busy high k+1..k+17, done pulse at k+18, rd=0x0000002A.
- MULH rs1=rs2=0x80000000 → rd=0x40000000. MULH rs1=rs2=0xFFFFFFFF → rd=0x00000000.
- MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → rd=0xFFFFFFFF. MULHU with the same operands → rd=0xFFFFFFFE.
- Mid-operation events: start MUL 3*5, assert enable with new operands at k+4, reset at k+6 → enable ignored; busy=0 and rd=0 at k+7; no done.
- Abort: start MUL 3*5 after a prior result rd=0x2A, abort at k+5 → busy=0 at k+6, rd stays 0x2A, no done. A new MUL 3*5 started afterwards → rd=0x0F.
- With MUL_ZERO_BYPASS_EN: MULHU rs1=0, rs2=0x12345678 → done at k+2, rd=0. Repeat without the macro → done at k+18, rd=0. Repeat with XLEN=64, BPC=4, MULHU both operands all-ones → done at k+18, rd=0xFFFFFFFFFFFFFFFE.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared operation codes, FSM state encoding and parameter
// legality helpers for the iterative multiplier.
package mul_pkg;

  // funct3[1:0] encodings of the M-extension multiply group
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    ITER = 2'b10,
    FIX  = 2'b11
  } mul_state_e;

  // Bits retired per iteration: only 1, 2 or 4 are supported
  function automatic bit mul_bpc_legal(int unsigned bpc);
    return (bpc == 32'd1) || (bpc == 32'd2) || (bpc == 32'd4);
  endfunction

  // Operand width: RV32 or RV64 only
  function automatic bit mul_xlen_legal(int unsigned xlen);
    return (xlen == 32'd32) || (xlen == 32'd64);
  endfunction

endpackage

// File: rtl/mul_step.sv
// mul_step: one radix-2^BPC partial-product step of a right-shifting
// accumulator. The digit product |a|*digit is added into the upper half and
// the whole accumulator then shifts right by BPC, so after XLEN/BPC steps
// every digit has landed at its own weight.
module mul_step
  import mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 2
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   mcand_i,
  input  logic [BPC-1:0]    digit_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN+BPC-1:0]   pp_s;
  logic [2*XLEN+BPC-1:0] sum_s;

  // Partial product, add at the top, then retire BPC bits
  always_comb begin
    pp_s  = {{BPC{1'b0}}, mcand_i} * {{XLEN{1'b0}}, digit_i};
    sum_s = {{BPC{1'b0}}, acc_i} + {pp_s, {XLEN{1'b0}}};
    acc_o = sum_s[2*XLEN+BPC-1:BPC];
  end

endmodule

// File: rtl/mul_iter_param.sv
// mul_iter_param: iterative XLEN x XLEN multiplier for MUL/MULH/MULHSU/MULHU.
// Sign-magnitude scheme: PREP takes operand magnitudes, ITER accumulates
// XLEN/BPC digit steps, the final sign fix and half select are folded into
// the last ITER edge so rd/done are registered and visible in the FIX cycle.
// Optional build macro: MUL_ZERO_BYPASS_EN (zero operand skips ITER).
module mul_iter_param
  import mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            abort,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] rd,
  output logic            busy,
  output logic            done
);

  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]     CNT_INIT = CW'(N);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};

  generate
    if (!mul_bpc_legal(BPC) || ((XLEN % BPC) != 0)) begin : g_bad_bpc
      $error("mul_iter_param: BPC must be 1, 2 or 4 and divide XLEN");
    end
    if (!mul_xlen_legal(XLEN)) begin : g_bad_xlen
      $error("mul_iter_param: XLEN must be 32 or 64");
    end
  endgenerate

  mul_state_e        state_q;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic              sign_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   rd_q;
  logic              busy_q;
  logic              done_q;

  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   res_s;

  // Operand signedness and magnitudes; the most negative value maps to
  // 2^(XLEN-1), which is representable as an unsigned XLEN-bit magnitude
  always_comb begin
    a_neg_s = ((op_q == MUL_OP_MULH) || (op_q == MUL_OP_MULHSU)) && mcand_q[XLEN-1];
    b_neg_s = (op_q == MUL_OP_MULH) && mplier_q[XLEN-1];
    if (a_neg_s) begin
      a_mag_s = ~mcand_q + ONE_X;
    end else begin
      a_mag_s = mcand_q;
    end
    if (b_neg_s) begin
      b_mag_s = ~mplier_q + ONE_X;
    end else begin
      b_mag_s = mplier_q;
    end
  end

  mul_step #(
    .XLEN (XLEN),
    .BPC  (BPC)
  ) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .digit_i (mplier_q[BPC-1:0]),
    .acc_o   (acc_d)
  );

  // Sign correction and half select on the final accumulated product
  always_comb begin
    if (sign_q) begin
      prod_s = ~acc_d + ONE_2X;
    end else begin
      prod_s = acc_d;
    end
    if (op_q == MUL_OP_MUL) begin
      res_s = prod_s[XLEN-1:0];
    end else begin
      res_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Control FSM with registered rd/busy/done
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= MUL_OP_MUL;
      mcand_q  <= {XLEN{1'b0}};
      mplier_q <= {XLEN{1'b0}};
      sign_q   <= 1'b0;
      acc_q    <= {(2*XLEN){1'b0}};
      cnt_q    <= {CW{1'b0}};
      rd_q     <= {XLEN{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // FIX is the done cycle and behaves like IDLE for a new start
        IDLE, FIX: begin
          if (enable && !abort) begin
            op_q     <= op;
            mcand_q  <= rs1;
            mplier_q <= rs2;
            busy_q   <= 1'b1;
            state_q  <= PREP;
          end else begin
            state_q  <= IDLE;
          end
        end
        PREP: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            mcand_q  <= a_mag_s;
            mplier_q <= b_mag_s;
            sign_q   <= a_neg_s ^ b_neg_s;
            acc_q    <= {(2*XLEN){1'b0}};
            cnt_q    <= CNT_INIT;
`ifdef MUL_ZERO_BYPASS_EN
            if ((mcand_q == {XLEN{1'b0}}) || (mplier_q == {XLEN{1'b0}})) begin
              rd_q    <= {XLEN{1'b0}};
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FIX;
            end else begin
              state_q <= ITER;
            end
`else
            state_q <= ITER;
`endif
          end
        end
        ITER: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q    <= acc_d;
            mplier_q <= mplier_q >> BPC;
            cnt_q    <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              rd_q    <= res_s;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FIX;
            end else begin
              state_q <= ITER;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd   = rd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
